// File: rtl/cpu_program_loader.sv
// cpu_program_loader: receives a program byte stream over valid/ready and
// assembles it into the flat program image of the 8-bit accumulator CPU.
// While loading it holds the CPU in reset. It then releases the CPU to run,
// watches the halt flag, and stops the run with a cycle-limit watchdog.
module cpu_program_loader #(
  parameter int MEM_BYTES  = 8,
  parameter int MAX_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_req,
  input  logic                   abort,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   cpu_halt,
  output logic [MEM_BYTES*8-1:0] i_mem,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [15:0]            run_cycles
);

  localparam int PW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic            hs, last_byte, start, abort_hit;
  logic            halt_ok, wd_hit;
  logic [15:0]     cyc_nxt;

  // Handshake and exit conditions. The run counter includes the current
  // cycle, so the watchdog compares against the incremented value.
  assign hs        = (state == LOAD) && in_valid;
  assign last_byte = hs && (in_last || (ptr == PW'(MEM_BYTES - 1)));
  assign cyc_nxt   = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
  // In the first RUN cycle the counter is still 0 and the CPU is still
  // leaving reset, so a halt seen then is not trusted.
  assign halt_ok   = cpu_halt && (run_cycles != 16'd0);
  assign wd_hit    = (cyc_nxt == 16'(MAX_CYCLES));
  assign abort_hit = abort && (state != IDLE);
  assign start     = (state_nxt == LOAD) && ((state == IDLE) || (state == DONE));

  // The outputs are decoded from the state register only.
  assign cpu_rst  = (state == IDLE) || (state == LOAD);
  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD) || (state == RUN);
  assign done     = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. An abort overrides every state-specific transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load_req)            state_nxt = LOAD;
      LOAD: if (last_byte)           state_nxt = RUN;
      RUN:  if (halt_ok || wd_hit)   state_nxt = DONE;
      DONE: if (load_req)            state_nxt = LOAD;
      default:                       state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  // Image, pointer, run counter and timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      i_mem      <= '0;
      ptr        <= '0;
      timeout    <= 1'b0;
      run_cycles <= '0;
    end else if (start) begin
      i_mem      <= '0;
      ptr        <= '0;
      timeout    <= 1'b0;
      run_cycles <= '0;
    end else if (abort_hit) begin
      ptr <= '0;
    end else begin
      case (state)
        LOAD: if (hs) begin
          for (int k = 0; k < MEM_BYTES; k++)
            if (ptr == PW'(k)) i_mem[k*8 +: 8] <= in_data;
          ptr <= ptr + 1'b1;
        end
        RUN: begin
          run_cycles <= cyc_nxt;
          if (halt_ok)     timeout <= 1'b0;
          else if (wd_hit) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader. The stimulus pushes the expected result of
// each run onto a scoreboard. A monitor pops an entry whenever done rises
// and compares it. Intermediate states are checked directly from the
// stimulus thread.
module tb_cpu_program_loader;

  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst, load_req, abort, in_valid, in_last, cpu_halt;
  logic [7:0]    in_data;
  logic          in_ready, cpu_rst, busy, done, timeout;
  logic [MB*8-1:0] i_mem;
  logic [15:0]   run_cycles;

  typedef struct {
    logic [63:0] imem;
    logic        to;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  logic prev_done = 1'b0;

  cpu_program_loader #(.MEM_BYTES(MB), .MAX_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .cpu_halt(cpu_halt), .i_mem(i_mem),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .timeout(timeout),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic push(input logic [63:0] m, input logic t, input logic [15:0] c);
    exp_t e;
    e.imem = m; e.to = t; e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per completed run, sampled off the active edge
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_done: got done=1 want no completion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("run_imem",    i_mem,      e.imem);
        chk("run_timeout", timeout,    e.to);
        chk("run_cycles",  run_cycles, e.cyc);
      end
    end
    prev_done = done;
  end

  initial begin
    rst = 1'b1; load_req = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_last = 1'b0; cpu_halt = 1'b0; in_data = 8'h00;
    step(); step();
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy_done", {busy, done, timeout}, 0);
    chk("rst_imem", i_mem, 0);
    chk("rst_cycles", run_cycles, 0);
    rst = 1'b0;
    step();

    // Test 1: full back-to-back load followed by a halt in the fourth RUN cycle
    load_req = 1'b1; step(); load_req = 1'b0;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_cpu_rst_load", cpu_rst, 1);
    send(8'h02, 0); send(8'h05, 0); send(8'h07, 0); send(8'h00, 0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 1);
    chk("t1_run_cpu_rst", cpu_rst, 0);
    chk("t1_run_in_ready", in_ready, 0);
    chk("t1_imem_load", i_mem, 64'h0000_0000_0007_0502);
    push(64'h0000_0000_0007_0502, 1'b0, 16'd4);
    cpu_halt = 1'b1; step(); cpu_halt = 1'b0;   // ignored: first RUN cycle
    chk("t1_halt_ignored", done, 0);
    step(); step();
    cpu_halt = 1'b1; step(); cpu_halt = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_done_cpu_rst", cpu_rst, 0);

    // Test 2: short jump-to-self program that ends through the watchdog
    load_req = 1'b1; step(); load_req = 1'b0;
    chk("t2_clear_imem", i_mem, 0);
    chk("t2_in_ready", in_ready, 1);
    push(64'h0000_0000_0000_0001, 1'b1, 16'd20);
    send(8'h01, 0); send(8'h00, 1);
    begin
      int n = 0;
      while (!done && n < 40) begin step(); n++; end
      chk("t2_wd_within_bound", done, 1);
    end

    // Test 3: in_valid toggles (in_last on idle cycles must be ignored),
    // and a load_req pulse during RUN must be ignored
    load_req = 1'b1; step(); load_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b0; in_last = 1'b1; in_data = 8'hFF;
      step();
      in_last = 1'b0;
      chk("t3_ready_gap", in_ready, 1);
      send(8'hA0 + 8'(k), k == 2);
      if (k < 2) chk("t3_ready_hs", in_ready, 1);
    end
    chk("t3_imem", i_mem, 64'h0000_0000_00A2_A1A0);
    push(64'h0000_0000_00A2_A1A0, 1'b0, 16'd3);
    load_req = 1'b1; step(); load_req = 1'b0;
    chk("t3_ldreq_ignored", {busy, in_ready, cpu_rst}, 3'b100);
    step();
    cpu_halt = 1'b1; step(); cpu_halt = 1'b0;
    chk("t3_done", done, 1);

    // Test 4: abort after three bytes, reload from byte 0, then rst during RUN
    load_req = 1'b1; step(); load_req = 1'b0;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("t4_abort_cpu_rst", cpu_rst, 1);
    chk("t4_abort_idle", {busy, done, in_ready}, 0);
    chk("t4_abort_keep", i_mem, 64'h0000_0000_0033_2211);
    load_req = 1'b1; step(); load_req = 1'b0;
    chk("t4_reload_clear", i_mem, 0);
    send(8'h44, 1);
    chk("t4_restart_ptr0", i_mem, 64'h0000_0000_0000_0044);
    for (int k = 0; k < 7; k++) step();
    chk("t4_cycles7", run_cycles, 7);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t4_rst_imem", i_mem, 0);
    chk("t4_rst_cycles", run_cycles, 0);
    chk("t4_rst_cpu_rst", cpu_rst, 1);
    chk("t4_rst_flags", {busy, done, in_ready, timeout}, 0);

    step(); step();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cpu_program_loader.md
# cpu_program_loader

Upstream companion to the 8-bit accumulator CPU. Accepts a byte stream over a valid/ready handshake and assembles it into the CPU's flat 8-byte program memory image. It holds the CPU in reset while loading, releases it to run, and watches the CPU's halt flag, with a cycle-limit watchdog. The CPU's `i_mem` and `rst` inputs are driven directly from this block.

## Interface

Parameters:
- `MEM_BYTES`, 8: program image size in bytes; `i_mem` is `MEM_BYTES*8` bits.
- `MAX_CYCLES`, 255: run-cycle limit before forced timeout; must be 1..65535.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `load_req`  in  1  start a new load; honoured only in IDLE or DONE.
- `abort`  in  1  return to IDLE from any non-IDLE state.
- `in_data`  in  8  program byte.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  qualifies the current byte as the final byte of the program.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `cpu_halt`  in  1  CPU halt flag.
- `i_mem`  out  `MEM_BYTES*8`  program image; byte k is at `[k*8 +: 8]`.
- `cpu_rst`  out  1  reset to the CPU.
- `busy`  out  1  state is LOAD or RUN.
- `done`  out  1  state is DONE.
- `timeout`  out  1  last run ended by the watchdog; valid while `done`.
- `run_cycles`  out  16  cycles spent in RUN for the current or last run.

## Operation

- Reset values: state IDLE, `i_mem`=0, `cpu_rst`=1, `in_ready`=0, `busy`=0, `done`=0, `timeout`=0, `run_cycles`=0, byte pointer `ptr`=0.
- All outputs are decoded from registered state; there is no combinational path from inputs to outputs.
- Priority per cycle: `rst` > `abort` > state-specific behaviour.

States and transitions:
- IDLE: `cpu_rst`=1. `load_req` moves to LOAD and, on the same edge, clears `i_mem` to 0, `ptr` to 0, `timeout` to 0 and `run_cycles` to 0.
- LOAD: `cpu_rst`=1, `in_ready`=1.
  - A handshake (`in_valid`&`in_ready`) writes `in_data` to byte `ptr` and increments `ptr`.
  - If the accepted byte has `in_last`=1 or `ptr`==`MEM_BYTES`-1, the state moves to RUN.
  - Unwritten bytes stay 0. Opcode 0 is an invalid opcode, so the CPU halts on reaching it.
- RUN: `cpu_rst`=0, `in_ready`=0.
  - `run_cycles` increments each cycle and saturates at 65535.
  - `cpu_halt` is ignored in the first RUN cycle, because the CPU is still leaving reset.
  - From the second RUN cycle, `cpu_halt`=1 moves the state to DONE with `timeout`=0.
  - If `run_cycles` equals `MAX_CYCLES` and `cpu_halt`=0, the state moves to DONE with `timeout`=1.
  - If both conditions hold in the same cycle, halt wins and `timeout`=0.
- DONE: `cpu_rst`=0, so the CPU keeps its halted state and its outputs stay observable. `i_mem` and `run_cycles` are held. `load_req` moves to LOAD with the same clears as from IDLE.
- `abort` in LOAD, RUN or DONE moves to IDLE. `i_mem` keeps its contents, `ptr` is set to 0, and `cpu_rst` is 1 from the next cycle.
- `load_req` in LOAD or RUN is ignored.
- Input bytes arriving while `in_ready`=0 are not consumed.
- `in_last` without `in_valid` has no effect.

## Timing

- Handshake: a byte is accepted on the rising edge where `in_valid`&`in_ready`=1. `in_ready` may be high for back-to-back bytes, giving one byte per cycle.
- Load latency: `load_req` at edge t gives `in_ready`=1 from cycle t+1.
- Last byte accepted at edge t gives RUN with `cpu_rst`=0 from cycle t+1; byte writes are visible on `i_mem` from t+1.
- The CPU's first instruction executes at edge t+2, the first edge where the CPU samples `cpu_rst`=0.
- Halt latency: `cpu_halt` high at edge t gives `done`=1 from cycle t+1.
- `run_cycles` counts RUN cycles, including the cycle in which the exit condition is sampled.
- `rst` mid-load or mid-run: on the next cycle all outputs take their reset values and the partial image is discarded (`i_mem`=0).

## Test plan

- Full load of bytes 02 05 07 00 00 00 00 00, back-to-back, last on byte 8 -> `i_mem`=64'h0000_0000_0007_0502; RUN begins the cycle after byte 8; halt on opcode 0 gives `done`=1, `timeout`=0, `run_cycles`=4.
- Short load of 01 00 with `in_last` on byte 2 (a jump-to-self loop), `MAX_CYCLES`=20 -> bytes 2..7 = 0; `done`=1 with `timeout`=1 and `run_cycles`=20.
- `in_valid` toggling every other cycle during LOAD -> only handshaken bytes are written, at consecutive pointers; `in_ready` stays 1 throughout LOAD.
- `abort` asserted after 3 bytes -> IDLE next cycle with `cpu_rst`=1; a following `load_req` clears `i_mem` to 0 and restarts at byte 0.
- `load_req` pulsed during RUN -> ignored; the run completes normally. `load_req` in DONE -> `i_mem` cleared and `in_ready`=1 the next cycle.
- `rst` asserted during RUN with `run_cycles`=7 -> next cycle shows IDLE, `run_cycles`=0, `i_mem`=0 and `cpu_rst`=1.
